// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port 256 B big-endian data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                p0_done_q, p0_done_d, p1_done_q, p1_done_d;
  logic                p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                pick;
  logic                acc_err;
`ifdef ARB_ROUND_ROBIN_EN
  logic                rr_last_q, rr_last_d;
`endif

  // pick = 1 selects port 1
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) pick = ~rr_last_q;
    else                  pick = ~p0_req;
`else
    pick = ~p0_req;
`endif
  end

  assign acc_err = (addr_q[1:0] != 2'b00) | (addr_q > LAST_WORD);

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_err_d   = p0_err_q;
    p1_err_d   = p1_err_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d  = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d = ACCESS;
          win_d   = pick;
          we_d    = pick ? p1_we    : p0_we;
          addr_d  = pick ? p1_addr  : p0_addr;
          wdata_d = pick ? p1_wdata : p0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = pick;
`endif
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        // Writes leave rdata alone; errors force it to zero.
        if (win_q) begin
          p1_done_d = 1'b1;
          p1_err_d  = acc_err;
          if (acc_err)    p1_rdata_d = '0;
          else if (!we_q) p1_rdata_d = mem_rdata;
        end else begin
          p0_done_d = 1'b1;
          p0_err_d  = acc_err;
          if (acc_err)    p0_rdata_d = '0;
          else if (!we_q) p0_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_err_q   <= p0_err_d;
      p1_err_q   <= p1_err_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end

  // Strobes decode from state so an async reset drops them at once.
  assign p0_gnt    = (state_q == ACCESS) & ~win_q;
  assign p1_gnt    = (state_q == ACCESS) &  win_q;
  assign mem_read  = (state_q == ACCESS) & ~acc_err & ~we_q;
  assign mem_write = (state_q == ACCESS) & ~acc_err &  we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
